mp_register_file: RTL and testbench

- Next-generation register file: parametrised read ports (RD_PORTS) and write ports (WR_PORTS).
- Optional hardwired zero register.
- Optional same-cycle write-to-read bypass.
- Per-register pending-write scoreboard (busy bits) so the pipeline can detect RAW hazards without external tracking.
- Sits between the decode/issue stage (reads, allocations) and the writeback stage (writes) of the datapath.

---
 rtl/rf_pkg.sv | 26 ++
 rtl/rf_read_port.sv | 72 +++++++
 rtl/mp_register_file.sv | 106 ++++++++++
 tb/tb_mp_register_file.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants, helpers and packing macros for the multi-port register file.
// Packed port p of width w inside a flat vector.
`ifndef RF_PKG_MACROS
`define RF_PKG_MACROS
`define RF_SLICE(vec, idx, w) vec[(w)*(idx) +: (w)]
`endif

package rf_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_REG_DEPTH  = 32;

    // Address width for a given depth; never returns less than 1 bit.
    function automatic int unsigned rf_clog2(input int unsigned value);
        int unsigned bits;
        int unsigned rem;
        bits = 0;
        rem  = (value > 1) ? value - 1 : 0;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage mux, same-cycle write bypass,
// zero/out-of-range masking and pending-operand flag.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned REG_DEPTH  = RF_REG_DEPTH,
    parameter int unsigned ADDR_WIDTH = rf_clog2(REG_DEPTH),
    parameter int unsigned WR_PORTS   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic [DATA_WIDTH*REG_DEPTH-1:0] i_regs,
    input  logic [REG_DEPTH-1:0]            i_busy,
    input  logic [WR_PORTS-1:0]             i_wr_en,
    input  logic [ADDR_WIDTH*WR_PORTS-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH*WR_PORTS-1:0]  i_wr_data,
    input  logic [ADDR_WIDTH-1:0]           i_rd_addr,
    output logic [DATA_WIDTH-1:0]           o_rd_data,
    output logic                            o_rd_busy
);

    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_stored;
    logic                  w_stored_busy;
    logic                  w_byp_hit;
    logic [DATA_WIDTH-1:0] w_byp_data;
    logic                  w_zero;

    always_comb begin
        w_in_range    = 1'b0;
        w_stored      = '0;
        w_stored_busy = 1'b0;
        // Addresses at or beyond REG_DEPTH match no entry and stay out of range.
        for (int r = 0; r < int'(REG_DEPTH); r++) begin
            if (i_rd_addr == ADDR_WIDTH'(r)) begin
                w_in_range    = 1'b1;
                w_stored      = `RF_SLICE(i_regs, r, DATA_WIDTH);
                w_stored_busy = i_busy[r];
            end
        end
    end

    always_comb begin
        w_byp_hit  = 1'b0;
        w_byp_data = '0;
        // Ascending scan so the highest-index enabled port wins a collision.
        for (int p = 0; p < int'(WR_PORTS); p++) begin
            if (i_wr_en[p] && (`RF_SLICE(i_wr_addr, p, ADDR_WIDTH) == i_rd_addr)) begin
                w_byp_hit  = 1'b1;
                w_byp_data = `RF_SLICE(i_wr_data, p, DATA_WIDTH);
            end
        end
    end

    assign w_zero = (ZERO_REG != 0) && (i_rd_addr == '0);

    always_comb begin
        o_rd_data = '0;
        o_rd_busy = 1'b0;
        if (w_in_range && !w_zero) begin
            if ((BYPASS != 0) && w_byp_hit) begin
                o_rd_data = w_byp_data;
                o_rd_busy = 1'b0;
            end else begin
                o_rd_data = w_stored;
                o_rd_busy = w_stored_busy;
            end
        end
    end

endmodule

// File: rtl/mp_register_file.sv
// Multi-port register file with optional zero register, write-to-read bypass
// and a per-register pending-write scoreboard for RAW hazard detection.
module mp_register_file
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned REG_DEPTH  = RF_REG_DEPTH,
    parameter int unsigned ADDR_WIDTH = rf_clog2(REG_DEPTH),
    parameter int unsigned RD_PORTS   = 2,
    parameter int unsigned WR_PORTS   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WR_PORTS-1:0]            wr_en,
    input  logic [ADDR_WIDTH*WR_PORTS-1:0] wr_addr,
    input  logic [DATA_WIDTH*WR_PORTS-1:0] wr_data,
    input  logic [ADDR_WIDTH*RD_PORTS-1:0] rd_addr,
    output logic [DATA_WIDTH*RD_PORTS-1:0] rd_data,
    output logic [RD_PORTS-1:0]            rd_busy,
    input  logic                           alloc_en,
    input  logic [ADDR_WIDTH-1:0]          alloc_addr,
    output logic [REG_DEPTH-1:0]           busy_vec
);

    logic [DATA_WIDTH-1:0]           r_regs [REG_DEPTH];
    logic [REG_DEPTH-1:0]            r_busy;

    logic [REG_DEPTH-1:0]            w_we;
    logic [DATA_WIDTH-1:0]           w_wd [REG_DEPTH];
    logic [REG_DEPTH-1:0]            w_alloc;
    logic [REG_DEPTH-1:0]            w_busy_d;
    logic [DATA_WIDTH*REG_DEPTH-1:0] w_regs_flat;

    // Per-register write/alloc decode; register 0 is skipped entirely when hardwired.
    always_comb begin
        w_we    = '0;
        w_alloc = '0;
        for (int r = 0; r < int'(REG_DEPTH); r++) begin
            w_wd[r] = '0;
        end
        for (int r = 0; r < int'(REG_DEPTH); r++) begin
            if (!((ZERO_REG != 0) && (r == 0))) begin
                for (int p = 0; p < int'(WR_PORTS); p++) begin
                    if (wr_en[p] && (`RF_SLICE(wr_addr, p, ADDR_WIDTH) == ADDR_WIDTH'(r))) begin
                        w_we[r] = 1'b1;
                        w_wd[r] = `RF_SLICE(wr_data, p, DATA_WIDTH);
                    end
                end
                if (alloc_en && (alloc_addr == ADDR_WIDTH'(r))) begin
                    w_alloc[r] = 1'b1;
                end
            end
        end
    end

    // A same-cycle alloc outranks the clearing write: the newer producer owns the register.
    assign w_busy_d = (r_busy & ~w_we) | w_alloc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(REG_DEPTH); r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 0; r < int'(REG_DEPTH); r++) begin
                if (w_we[r]) begin
                    r_regs[r] <= w_wd[r];
                end
            end
            r_busy <= w_busy_d;
        end
    end

    always_comb begin
        w_regs_flat = '0;
        for (int r = 0; r < int'(REG_DEPTH); r++) begin
            `RF_SLICE(w_regs_flat, r, DATA_WIDTH) = r_regs[r];
        end
    end

    assign busy_vec = r_busy;

    for (genvar k = 0; k < int'(RD_PORTS); k++) begin : g_rd
        rf_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_DEPTH  (REG_DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .WR_PORTS   (WR_PORTS),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_rd (
            .i_regs    (w_regs_flat),
            .i_busy    (r_busy),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_addr (`RF_SLICE(rd_addr, k, ADDR_WIDTH)),
            .o_rd_data (`RF_SLICE(rd_data, k, DATA_WIDTH)),
            .o_rd_busy (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_mp_register_file.sv
// Self-checking bench for mp_register_file (default parameters: zero register and bypass on).
module tb_mp_register_file;

    localparam int DW = 32;
    localparam int RD = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    wr_en;
    logic [AW*NW-1:0] wr_addr;
    logic [DW*NW-1:0] wr_data;
    logic [AW*NR-1:0] rd_addr;
    logic [DW*NR-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             alloc_en;
    logic [AW-1:0]    alloc_addr;
    logic [RD-1:0]    busy_vec;

    int tests_run    = 0;
    int tests_failed = 0;

    // Architectural model: plain arrays of register contents and pending flags.
    logic [DW-1:0] m_regs [RD];
    bit   [RD-1:0] m_busy;

    mp_register_file dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_rd(input int a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        for (int p = 0; p < NW; p++)
            if (wr_en[p] && int'(wr_addr[AW*p +: AW]) == a) v = wr_data[DW*p +: DW];
        return v;
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
        for (int p = 0; p < NW; p++)
            if (wr_en[p] && int'(wr_addr[AW*p +: AW]) == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; alloc_en = 1'b0; alloc_addr = '0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[AW*p +: AW] = a;
        wr_data[DW*p +: DW] = d;
    endtask

    // Apply current inputs across one rising edge, update the model, return at the falling edge.
    task automatic step();
        logic [DW-1:0] n_regs [RD];
        bit   [RD-1:0] n_busy;
        for (int r = 0; r < RD; r++) n_regs[r] = m_regs[r];
        n_busy = m_busy;
        for (int p = 0; p < NW; p++) begin
            int a = int'(wr_addr[AW*p +: AW]);
            if (wr_en[p] && a != 0) begin
                n_regs[a] = wr_data[DW*p +: DW];
                n_busy[a] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != 0) n_busy[alloc_addr] = 1'b1;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < RD; r++) m_regs[r] = n_regs[r];
            m_busy = n_busy;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic model_clear();
        for (int r = 0; r < RD; r++) m_regs[r] = '0;
        m_busy = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rd_addr[0 +: AW] = 5'd5;
        #1;
        tests_run++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_vec !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: rd_data=%h rd_busy=%b busy_vec=%h, want all 0",
                     rd_data, rd_busy, busy_vec);
        end
        rst = 1'b1;
        step();
        set_wr(0, 5'd5, 32'hDEADBEEF);
        alloc_en = 1'b1; alloc_addr = 5'd6;
        step();
        rd_addr[0 +: AW] = 5'd5;
        #1;
        tests_run++;
        if (rd_data[0 +: DW] !== 32'hDEADBEEF || busy_vec[6] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_prewrite: r5=%h busy6=%b, want deadbeef 1",
                     rd_data[0 +: DW], busy_vec[6]);
        end
        // In-flight write and alloc, then reset asserted mid-cycle.
        set_wr(1, 5'd5, 32'h11111111);
        alloc_en = 1'b1; alloc_addr = 5'd8;
        rd_addr[0 +: AW] = 5'd4;
        rd_addr[AW +: AW] = 5'd6;
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (rd_data !== '0 || busy_vec !== '0 || rd_busy !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: rd_data=%h busy_vec=%h rd_busy=%b, want 0",
                     rd_data, busy_vec, rd_busy);
        end
        model_clear();
        step();
        rst = 1'b1;
        rd_addr[0 +: AW] = 5'd5;
        rd_addr[AW +: AW] = 5'd8;
        #1;
        tests_run++;
        if (rd_data !== '0 || busy_vec !== '0) begin
            tests_failed++;
            $display("FAIL reset_discard: rd_data=%h busy_vec=%h, want 0", rd_data, busy_vec);
        end
    endtask

    task automatic test_write_read();
        idle();
        set_wr(0, 5'd3, 32'h12345678);
        rd_addr[0 +: AW] = 5'd3;
        #1;
        tests_run++;
        if (rd_data[0 +: DW] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL wr_bypass: got %h want 12345678", rd_data[0 +: DW]);
        end
        step();
        rd_addr[AW +: AW] = 5'd3;
        #1;
        tests_run++;
        if (rd_data[AW == 0 ? 0 : DW +: DW] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL wr_next_cycle: got %h want 12345678", rd_data[DW +: DW]);
        end
    endtask

    task automatic test_collision();
        idle();
        set_wr(0, 5'd7, 32'h1);
        set_wr(1, 5'd7, 32'h2);
        rd_addr[0 +: AW] = 5'd7;
        #1;
        tests_run++;
        if (rd_data[0 +: DW] !== 32'h2) begin
            tests_failed++;
            $display("FAIL collision_bypass: got %h want 2", rd_data[0 +: DW]);
        end
        step();
        rd_addr[AW +: AW] = 5'd7;
        #1;
        tests_run++;
        if (rd_data[DW +: DW] !== 32'h2) begin
            tests_failed++;
            $display("FAIL collision_store: got %h want 2", rd_data[DW +: DW]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        alloc_en = 1'b1; alloc_addr = 5'd0;
        rd_addr[0 +: AW] = 5'd0;
        #1;
        tests_run++;
        if (rd_data[0 +: DW] !== '0 || rd_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_bypass: data=%h busy=%b want 0 0", rd_data[0 +: DW], rd_busy[0]);
        end
        step();
        rd_addr[AW +: AW] = 5'd0;
        #1;
        tests_run++;
        if (rd_data[DW +: DW] !== '0 || busy_vec[0] !== 1'b0 || rd_busy[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_store: data=%h busy_vec0=%b want 0 0",
                     rd_data[DW +: DW], busy_vec[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd9;
        step();
        rd_addr[0 +: AW] = 5'd9;
        #1;
        tests_run++;
        if (busy_vec[9] !== 1'b1 || rd_busy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_alloc: busy_vec9=%b rd_busy=%b want 1 1", busy_vec[9], rd_busy[0]);
        end
        // WAW re-alloc keeps it pending.
        alloc_en = 1'b1; alloc_addr = 5'd9;
        step();
        set_wr(1, 5'd9, 32'hAA);
        rd_addr[0 +: AW] = 5'd9;
        #1;
        tests_run++;
        if (rd_busy[0] !== 1'b0 || rd_data[0 +: DW] !== 32'hAA || busy_vec[9] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_write_bypass: rd_busy=%b data=%h busy_vec9=%b want 0 aa 1",
                     rd_busy[0], rd_data[0 +: DW], busy_vec[9]);
        end
        step();
        #1;
        tests_run++;
        if (busy_vec[9] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_clear: busy_vec9=%b want 0", busy_vec[9]);
        end
        // Write to a non-pending register leaves it non-pending.
        set_wr(0, 5'd10, 32'h5);
        step();
        #1;
        tests_run++;
        if (busy_vec[10] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_nonbusy_write: busy_vec10=%b want 0", busy_vec[10]);
        end
    endtask

    task automatic test_alloc_write_same();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd9;
        set_wr(0, 5'd9, 32'hCAFE0009);
        step();
        rd_addr[0 +: AW] = 5'd9;
        #1;
        tests_run++;
        if (busy_vec[9] !== 1'b1 || rd_data[0 +: DW] !== 32'hCAFE0009 || rd_busy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL alloc_write_same: busy_vec9=%b data=%h rd_busy=%b want 1 cafe0009 1",
                     busy_vec[9], rd_data[0 +: DW], rd_busy[0]);
        end
        set_wr(1, 5'd9, 32'h0);
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int range;
            idle();
            range = ($urandom_range(0, 1) == 0) ? 7 : 31;
            for (int p = 0; p < NW; p++)
                if ($urandom_range(0, 2) != 0) set_wr(p, AW'($urandom_range(0, range)), $urandom);
            alloc_en = ($urandom_range(0, 2) == 0);
            alloc_addr = AW'($urandom_range(0, range));
            for (int k = 0; k < NR; k++) rd_addr[AW*k +: AW] = AW'($urandom_range(0, range));
            #1;
            for (int k = 0; k < NR; k++) begin
                int a = int'(rd_addr[AW*k +: AW]);
                tests_run++;
                if (rd_data[DW*k +: DW] !== exp_rd(a) || rd_busy[k] !== exp_busy(a)) begin
                    tests_failed++;
                    $display("FAIL rand_read c=%0d port=%0d addr=%0d: got %h/%b want %h/%b",
                             c, k, a, rd_data[DW*k +: DW], rd_busy[k], exp_rd(a), exp_busy(a));
                end
            end
            tests_run++;
            if (busy_vec !== m_busy) begin
                tests_failed++;
                $display("FAIL rand_busy_vec c=%0d: got %h want %h", c, busy_vec, m_busy);
            end
            step();
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_alloc_write_same();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
